// File: rtl/dtl_burst_arb_pkg.sv
// rtl/dtl_burst_arb_pkg.sv - shared state type, sizing helper and beat-counter width for the DTL burst arbiter
package dtl_burst_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } arb_state_e;

  localparam int ARB_BEAT_W = 5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dtl_burst_arbiter_if.sv
// rtl/dtl_burst_arbiter_if.sv - DTL port bundle; NUM>1 carries per-port packed slices, port i in slice i
interface dtl_burst_arbiter_if #(
  parameter int NUM         = 1,
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 5
);
  localparam int NUM_ENABLES = WIDTH / 8;

  logic [NUM-1:0]             CommandValid;
  logic [NUM-1:0]             CommandReadWrite;
  logic [NUM*ADDR_WIDTH-1:0]  Address;
  logic [NUM*BLOCK_WIDTH-1:0] BlockSize;
  logic [NUM-1:0]             CommandAccept;
  logic [NUM-1:0]             ReadValid;
  logic [NUM-1:0]             ReadLast;
  logic [NUM*WIDTH-1:0]       ReadData;
  logic [NUM-1:0]             ReadAccept;
  logic [NUM-1:0]             WriteValid;
  logic [NUM-1:0]             WriteLast;
  logic [NUM*NUM_ENABLES-1:0] WriteEnable;
  logic [NUM*WIDTH-1:0]       WriteData;
  logic [NUM-1:0]             WriteAccept;

  modport master (
    output CommandValid, CommandReadWrite, Address, BlockSize,
    output WriteValid, WriteLast, WriteEnable, WriteData, ReadAccept,
    input  CommandAccept, WriteAccept, ReadValid, ReadLast, ReadData
  );

  modport slave (
    input  CommandValid, CommandReadWrite, Address, BlockSize,
    input  WriteValid, WriteLast, WriteEnable, WriteData, ReadAccept,
    output CommandAccept, WriteAccept, ReadValid, ReadLast, ReadData
  );

endinterface

// File: rtl/dtl_burst_arbiter_rr_pick.sv
// rtl/dtl_burst_arbiter_rr_pick.sv - combinational round-robin pick: first request at or after ptr, wrapping
module rr_pick
  import dtl_burst_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic found;

  // Upper segment [ptr, N) first, then the wrapped segment [0, ptr).
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (!found && (p >= int'(ptr)) && req[p]) begin
        found     = 1'b1;
        onehot[p] = 1'b1;
        idx       = IW'(p);
      end
    end
    for (int p = 0; p < N; p++) begin
      if (!found && (p < int'(ptr)) && req[p]) begin
        found     = 1'b1;
        onehot[p] = 1'b1;
        idx       = IW'(p);
      end
    end
  end

endmodule

// File: rtl/dtl_burst_arbiter.sv
// rtl/dtl_burst_arbiter.sv - burst-locked round-robin share of one DTL master among NUM_PORTS slave ports
// Optional: DTL_BURST_ARB_PRIO0_EN gives port 0 absolute priority at each arbitration point.
module dtl_burst_arbiter
  import dtl_burst_arb_pkg::*;
#(
  parameter int INTERFACE_WIDTH       = 32,
  parameter int INTERFACE_ADDR_WIDTH  = 32,
  parameter int INTERFACE_BLOCK_WIDTH = ARB_BEAT_W,
  parameter int NUM_PORTS             = 2,
  parameter int INTERFACE_NUM_ENABLES = INTERFACE_WIDTH / 8
) (
  input  logic                         iClk,
  input  logic                         iReset,
  dtl_burst_arbiter_if.slave           dtl_in,
  dtl_burst_arbiter_if.master          dtl_out,
  output logic [clog2(NUM_PORTS)-1:0]  oOwner,
  output logic                         oProtocolError
);

  localparam int IW = clog2(NUM_PORTS);
  localparam int W  = INTERFACE_WIDTH;
  localparam int A  = INTERFACE_ADDR_WIDTH;
  localparam int B  = INTERFACE_BLOCK_WIDTH;
  localparam int E  = INTERFACE_NUM_ENABLES;

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   sel_q, sel_d, ptr_q, ptr_d;
  logic [B-1:0]    beats_q, beats_d;
  logic            err_q, err_d;

  logic [NUM_PORTS-1:0] win_oh, sel_oh;
  logic [IW-1:0]        win_idx, grant_idx;
  logic                 sel_cv, sel_rw, sel_wv, sel_wl, sel_ra;
  logic [A-1:0]         sel_addr;
  logic [B-1:0]         sel_bs;
  logic [E-1:0]         sel_we;
  logic [W-1:0]         sel_wd;
  logic                 data_hs, data_last;

  rr_pick #(.N(NUM_PORTS)) u_rr_pick (
    .req    (dtl_in.CommandValid),
    .ptr    (ptr_q),
    .onehot (win_oh),
    .idx    (win_idx)
  );

`ifdef DTL_BURST_ARB_PRIO0_EN
  assign grant_idx = dtl_in.CommandValid[0] ? '0 : win_idx;
`else
  assign grant_idx = win_idx;
`endif

  always_comb begin
    sel_oh   = '0;
    sel_cv   = 1'b0;
    sel_rw   = 1'b0;
    sel_addr = '0;
    sel_bs   = '0;
    sel_wv   = 1'b0;
    sel_wl   = 1'b0;
    sel_we   = '0;
    sel_wd   = '0;
    sel_ra   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_q == IW'(i)) begin
        sel_oh[i] = 1'b1;
        sel_cv    = dtl_in.CommandValid[i];
        sel_rw    = dtl_in.CommandReadWrite[i];
        sel_addr  = dtl_in.Address[i*A +: A];
        sel_bs    = dtl_in.BlockSize[i*B +: B];
        sel_wv    = dtl_in.WriteValid[i];
        sel_wl    = dtl_in.WriteLast[i];
        sel_we    = dtl_in.WriteEnable[i*E +: E];
        sel_wd    = dtl_in.WriteData[i*W +: W];
        sel_ra    = dtl_in.ReadAccept[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    beats_d   = beats_q;
    err_d     = err_q;
    data_hs   = 1'b0;
    data_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (|win_oh) begin
          sel_d   = grant_idx;
          state_d = CMD;
        end
      end
      CMD: begin
        if (sel_cv && dtl_out.CommandAccept[0]) begin
          beats_d = sel_bs;
          state_d = sel_rw ? RDATA : WDATA;
        end
      end
      RDATA, WDATA: begin
        data_hs   = (state_q == RDATA) ? (dtl_out.ReadValid[0] & sel_ra)
                                       : (sel_wv & dtl_out.WriteAccept[0]);
        data_last = (state_q == RDATA) ? dtl_out.ReadLast[0] : sel_wl;
        if (data_hs) begin
          // Last must coincide exactly with the counter reaching zero.
          if (data_last != (beats_q == '0)) err_d = 1'b1;
          if (beats_q != '0) beats_d = beats_q - 1'b1;
          if (data_last) begin
            state_d = IDLE;
            ptr_d   = (sel_q == IW'(NUM_PORTS - 1)) ? '0 : sel_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    dtl_out.CommandValid     = '0;
    dtl_out.CommandReadWrite = '0;
    dtl_out.Address          = '0;
    dtl_out.BlockSize        = '0;
    dtl_out.WriteValid       = '0;
    dtl_out.WriteLast        = '0;
    dtl_out.WriteEnable      = '0;
    dtl_out.WriteData        = '0;
    dtl_out.ReadAccept       = '0;
    dtl_in.CommandAccept     = '0;
    dtl_in.ReadValid         = '0;
    dtl_in.ReadLast          = '0;
    dtl_in.ReadData          = '0;
    dtl_in.WriteAccept       = '0;
    case (state_q)
      CMD: begin
        dtl_out.CommandValid     = sel_cv;
        dtl_out.CommandReadWrite = sel_rw;
        dtl_out.Address          = sel_addr;
        dtl_out.BlockSize        = sel_bs;
        dtl_in.CommandAccept     = sel_oh & {NUM_PORTS{dtl_out.CommandAccept[0]}};
      end
      RDATA: begin
        dtl_out.ReadAccept = sel_ra;
        dtl_in.ReadValid   = sel_oh & {NUM_PORTS{dtl_out.ReadValid[0]}};
        dtl_in.ReadLast    = sel_oh & {NUM_PORTS{dtl_out.ReadLast[0]}};
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (sel_oh[i]) dtl_in.ReadData[i*W +: W] = dtl_out.ReadData;
        end
      end
      WDATA: begin
        dtl_out.WriteValid  = sel_wv;
        dtl_out.WriteLast   = sel_wl;
        dtl_out.WriteEnable = sel_we;
        dtl_out.WriteData   = sel_wd;
        dtl_in.WriteAccept  = sel_oh & {NUM_PORTS{dtl_out.WriteAccept[0]}};
      end
      default: ;
    endcase
  end

  assign oOwner         = sel_q;
  assign oProtocolError = err_q;

endmodule

// File: tb/tb_dtl_burst_arbiter.sv
// tb/tb_dtl_burst_arbiter.sv - vector table, corner sequences and randomized model check for dtl_burst_arbiter
module tb_dtl_burst_arbiter;

  localparam int N = 2;
  localparam int W = 32;
  localparam int A = 32;
  localparam int B = 5;
  localparam int E = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic owner;
  logic perr;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dtl_burst_arbiter_if #(.NUM(N), .WIDTH(W), .ADDR_WIDTH(A), .BLOCK_WIDTH(B)) in_if ();
  dtl_burst_arbiter_if #(.NUM(1), .WIDTH(W), .ADDR_WIDTH(A), .BLOCK_WIDTH(B)) out_if ();

  dtl_burst_arbiter #(
    .INTERFACE_WIDTH(W), .INTERFACE_ADDR_WIDTH(A), .INTERFACE_BLOCK_WIDTH(B),
    .NUM_PORTS(N), .INTERFACE_NUM_ENABLES(E)
  ) dut (
    .iClk(clk), .iReset(rst_n), .dtl_in(in_if), .dtl_out(out_if),
    .oOwner(owner), .oProtocolError(perr)
  );

  typedef struct packed {
    logic [1:0]  cv;
    logic [1:0]  rw;
    logic [4:0]  bs;
    logic        cacc;
    logic        rv;
    logic        rl;
    logic [1:0]  ra;
    logic [1:0]  wv;
    logic [1:0]  wl;
    logic        wacc;
    logic [10:0] exp;   // {ocv, icacc[1:0], oracc, irv[1:0], owv, iwacc[1:0], owner, err}
  } vec_t;

  vec_t tbl [25];

  int   m_owner, m_sel, m_ptr, m_beats;
  bit   m_cmd, m_rd, m_err;

  function automatic vec_t mk(input logic [1:0] cv, input logic [1:0] rw, input logic [4:0] bs,
                              input logic cacc, input logic rv, input logic rl, input logic [1:0] ra,
                              input logic [1:0] wv, input logic [1:0] wl, input logic wacc,
                              input logic [10:0] exp);
    vec_t v;
    v = '{cv: cv, rw: rw, bs: bs, cacc: cacc, rv: rv, rl: rl, ra: ra, wv: wv, wl: wl, wacc: wacc, exp: exp};
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic zero_inputs();
    in_if.CommandValid = '0; in_if.CommandReadWrite = '0; in_if.Address = '0; in_if.BlockSize = '0;
    in_if.ReadAccept = '0; in_if.WriteValid = '0; in_if.WriteLast = '0; in_if.WriteEnable = '0;
    in_if.WriteData = '0;
    out_if.CommandAccept = '0; out_if.WriteAccept = '0; out_if.ReadValid = '0; out_if.ReadLast = '0;
    out_if.ReadData = '0;
  endtask

  task automatic apply(input vec_t v);
    in_if.CommandValid = v.cv;  in_if.CommandReadWrite = v.rw; in_if.BlockSize = {v.bs, v.bs};
    out_if.CommandAccept = v.cacc; out_if.ReadValid = v.rv; out_if.ReadLast = v.rl;
    in_if.ReadAccept = v.ra; in_if.WriteValid = v.wv; in_if.WriteLast = v.wl;
    out_if.WriteAccept = v.wacc;
  endtask

  function automatic logic [10:0] tbl_act();
    return {out_if.CommandValid, in_if.CommandAccept, out_if.ReadAccept, in_if.ReadValid,
            out_if.WriteValid, in_if.WriteAccept, owner, perr};
  endfunction

  function automatic logic [151:0] all_outs();
    return {out_if.CommandValid, out_if.CommandReadWrite, out_if.Address, out_if.BlockSize,
            in_if.CommandAccept, out_if.ReadAccept, in_if.ReadValid, in_if.ReadLast, in_if.ReadData,
            out_if.WriteValid, out_if.WriteLast, out_if.WriteEnable, out_if.WriteData,
            in_if.WriteAccept, owner, perr};
  endfunction

  // Expected outputs: only the current owner's slice carries traffic, and only in its phase.
  function automatic logic [151:0] model_expect();
    logic e_ocv = 1'b0, e_orw = 1'b0, e_oracc = 1'b0, e_owv = 1'b0, e_owl = 1'b0;
    logic [A-1:0] e_oaddr = '0;
    logic [B-1:0] e_obs = '0;
    logic [N-1:0] e_icacc = '0, e_irv = '0, e_irl = '0, e_iwacc = '0;
    logic [N*W-1:0] e_ird = '0;
    logic [E-1:0] e_owe = '0;
    logic [W-1:0] e_owd = '0;
    int o;
    o = m_owner;
    if (o >= 0) begin
      if (m_cmd) begin
        e_ocv = in_if.CommandValid[o]; e_orw = in_if.CommandReadWrite[o];
        e_oaddr = in_if.Address[o*A +: A]; e_obs = in_if.BlockSize[o*B +: B];
        e_icacc[o] = out_if.CommandAccept[0];
      end else if (m_rd) begin
        e_oracc = in_if.ReadAccept[o]; e_irv[o] = out_if.ReadValid[0];
        e_irl[o] = out_if.ReadLast[0]; e_ird[o*W +: W] = out_if.ReadData;
      end else begin
        e_owv = in_if.WriteValid[o]; e_owl = in_if.WriteLast[o];
        e_owe = in_if.WriteEnable[o*E +: E]; e_owd = in_if.WriteData[o*W +: W];
        e_iwacc[o] = out_if.WriteAccept[0];
      end
    end
    return {e_ocv, e_orw, e_oaddr, e_obs, e_icacc, e_oracc, e_irv, e_irl, e_ird,
            e_owv, e_owl, e_owe, e_owd, e_iwacc, 1'(m_sel), m_err};
  endfunction

  task automatic model_step();
    int o, pick;
    bit hs, last;
    o = m_owner;
    if (o < 0) begin
      if (in_if.CommandValid != '0) begin
        pick = -1;
`ifdef DTL_BURST_ARB_PRIO0_EN
        if (in_if.CommandValid[0]) pick = 0;
`endif
        for (int k = 0; k < N; k++)
          if (pick < 0 && in_if.CommandValid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        m_owner = pick; m_sel = pick; m_cmd = 1'b1;
      end
    end else if (m_cmd) begin
      if (in_if.CommandValid[o] && out_if.CommandAccept[0]) begin
        m_cmd = 1'b0; m_rd = in_if.CommandReadWrite[o];
        m_beats = int'(in_if.BlockSize[o*B +: B]);
      end
    end else begin
      hs   = m_rd ? (out_if.ReadValid[0] && in_if.ReadAccept[o]) : (in_if.WriteValid[o] && out_if.WriteAccept[0]);
      last = m_rd ? out_if.ReadLast[0] : in_if.WriteLast[o];
      if (hs) begin
        if (last && m_beats != 0) m_err = 1'b1;
        if (!last && m_beats == 0) m_err = 1'b1;
        if (m_beats > 0) m_beats--;
        if (last) begin m_ptr = (o + 1) % N; m_owner = -1; end
      end
    end
  endtask

  initial begin
    logic [1:0] wlv;
    bit inj;
    zero_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Single read (port 1, 4 beats, 3-cycle ReadAccept stall), contention, mid-burst request, short-Last error.
    tbl[0]  = mk(2'b10, 2'b10, 5'd3, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b0_00_0_00_0_00_0_0);
    tbl[1]  = mk(2'b10, 2'b10, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b1_10_0_00_0_00_1_0);
    tbl[2]  = mk(2'b00, 2'b00, 5'd3, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 11'b0_00_1_10_0_00_1_0);
    tbl[3]  = mk(2'b00, 2'b00, 5'd3, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b0_00_0_10_0_00_1_0);
    tbl[4]  = mk(2'b00, 2'b00, 5'd3, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b0_00_0_10_0_00_1_0);
    tbl[5]  = mk(2'b00, 2'b00, 5'd3, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b0_00_0_10_0_00_1_0);
    tbl[6]  = mk(2'b00, 2'b00, 5'd3, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 11'b0_00_1_10_0_00_1_0);
    tbl[7]  = mk(2'b00, 2'b00, 5'd3, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 11'b0_00_1_10_0_00_1_0);
    tbl[8]  = mk(2'b00, 2'b00, 5'd3, 1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 11'b0_00_1_10_0_00_1_0);
    tbl[9]  = mk(2'b00, 2'b00, 5'd3, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b0_00_0_00_0_00_1_0);
    tbl[10] = mk(2'b11, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b0_00_0_00_0_00_1_0);
    tbl[11] = mk(2'b11, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b1_01_0_00_0_00_0_0);
    tbl[12] = mk(2'b10, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b1, 11'b0_00_0_00_1_01_0_0);
    tbl[13] = mk(2'b10, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b0_00_0_00_0_00_0_0);
    tbl[14] = mk(2'b10, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b1_10_0_00_0_00_1_0);
    tbl[15] = mk(2'b00, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 1'b1, 11'b0_00_0_00_1_10_1_0);
    tbl[16] = mk(2'b01, 2'b00, 5'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b0_00_0_00_0_00_1_0);
    tbl[17] = mk(2'b01, 2'b00, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b1_01_0_00_0_00_0_0);
    tbl[18] = mk(2'b10, 2'b00, 5'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 11'b0_00_0_00_1_01_0_0);
    tbl[19] = mk(2'b10, 2'b00, 5'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b1, 11'b0_00_0_00_1_01_0_0);
    tbl[20] = mk(2'b10, 2'b10, 5'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b0_00_0_00_0_00_0_0);
    tbl[21] = mk(2'b10, 2'b10, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b1_10_0_00_0_00_1_0);
    tbl[22] = mk(2'b00, 2'b00, 5'd1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 11'b0_00_1_10_0_00_1_0);
    tbl[23] = mk(2'b00, 2'b00, 5'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b0_00_0_00_0_00_1_1);
    tbl[24] = mk(2'b00, 2'b00, 5'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'b0_00_0_00_0_00_1_1);

    @(negedge clk);
    #1 chk("reset_outputs", 256'(all_outs()), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1 chk($sformatf("vec%0d", i), 256'(tbl_act()), 256'(tbl[i].exp));
    end

    // Async reset while port 0 owns a write burst.
    @(negedge clk);
    apply(mk(2'b01, 2'b00, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'd0));
    @(negedge clk);
    apply(mk(2'b01, 2'b00, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'd0));
    @(negedge clk);
    apply(mk(2'b00, 2'b00, 5'd2, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 11'd0));
    #1 chk("wdata_before_reset", 256'({out_if.WriteValid, in_if.WriteAccept, owner, perr}), 256'(5'b1_00_0_1));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 256'(all_outs()), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(2'b01, 2'b00, 5'd2, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 11'd0));
    #1 chk("post_reset_idle", 256'(out_if.CommandValid), 256'(0));
    @(negedge clk);
    #1 chk("post_reset_grant", 256'({out_if.CommandValid, owner}), 256'(2'b10));

    // Randomized traffic against the reference model; Last errors injected only in the second half.
    @(negedge clk);
    rst_n = 1'b0;
    zero_inputs();
    m_owner = -1; m_sel = 0; m_ptr = 0; m_beats = 0; m_cmd = 1'b0; m_rd = 1'b0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      in_if.CommandValid     = 2'($urandom);
      in_if.CommandReadWrite = 2'($urandom);
      in_if.Address          = {$urandom, $urandom};
      in_if.BlockSize        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      in_if.ReadAccept       = 2'($urandom);
      in_if.WriteValid       = 2'($urandom);
      in_if.WriteEnable      = 8'($urandom);
      in_if.WriteData        = {$urandom, $urandom};
      for (int p = 0; p < N; p++) begin
        inj = (cyc >= 1500) && ($urandom_range(0, 199) == 0);
        wlv[p] = (m_beats == 0) ^ inj;
      end
      in_if.WriteLast        = wlv;
      inj = (cyc >= 1500) && ($urandom_range(0, 199) == 0);
      out_if.ReadLast        = 1'((m_beats == 0) ^ inj);
      out_if.CommandAccept   = 1'($urandom);
      out_if.ReadValid       = 1'($urandom);
      out_if.ReadData        = $urandom;
      out_if.WriteAccept     = 1'($urandom);
      #1 chk($sformatf("rand%0d", cyc), 256'(all_outs()), 256'(model_expect()));
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dtl_burst_arbiter.md
# dtl_burst_arbiter

Burst-aware scheduler that shares one DTL master port between NUM_PORTS DTL slave ports. A granted requester keeps the master port for its whole transaction: command, then every read or write beat up to and including the Last beat. Arbitration is round-robin and only happens at transaction boundaries. It sits between the core-side load/store DTL ports and the single memory-side DTL port, where the whole burst must stay with one owner.

## Interface
- INTERFACE_WIDTH, 32, data width in bits
- INTERFACE_ADDR_WIDTH, 32, address width
- INTERFACE_BLOCK_WIDTH, 5, BlockSize width (beats = BlockSize+1)
- NUM_PORTS, 2, number of requesters (>=2)
- INTERFACE_NUM_ENABLES, INTERFACE_WIDTH/8, byte enables per beat

Ports (clock and reset first; "per port" buses are packed, port i in slice i):
- iClk  in  1  sole clock, rising edge
- iReset  in  1  asynchronous, active-low reset
- iDTL_IN_CommandValid / iDTL_IN_CommandReadWrite  in  NUM_PORTS each  per-port command valid; 1=read, 0=write
- iDTL_IN_Address / iDTL_IN_BlockSize  in  NUM_PORTS*ADDR / NUM_PORTS*BLOCK  per-port command fields
- oDTL_IN_CommandAccept  out  NUM_PORTS  command accept, selected port only
- oDTL_IN_ReadValid / oDTL_IN_ReadLast  out  NUM_PORTS each  read beat routing
- oDTL_IN_ReadData  out  NUM_PORTS*WIDTH  read data; zero on non-selected slices
- iDTL_IN_ReadAccept  in  NUM_PORTS  read accept
- iDTL_IN_WriteValid / iDTL_IN_WriteLast  in  NUM_PORTS each  write beat valid / last
- iDTL_IN_WriteEnable / iDTL_IN_WriteData  in  NUM_PORTS*ENABLES / NUM_PORTS*WIDTH  write beat payload
- oDTL_IN_WriteAccept  out  NUM_PORTS  write accept
- oDTL_OUT_CommandValid, oDTL_OUT_CommandReadWrite, oDTL_OUT_Address, oDTL_OUT_BlockSize  out  1,1,ADDR,BLOCK  master command
- iDTL_OUT_CommandAccept  in  1  master command accept
- oDTL_OUT_WriteValid, oDTL_OUT_WriteLast, oDTL_OUT_WriteEnable, oDTL_OUT_WriteData  out  1,1,ENABLES,WIDTH  master write beat
- iDTL_OUT_WriteAccept  in  1  master write accept
- iDTL_OUT_ReadValid, iDTL_OUT_ReadLast, iDTL_OUT_ReadData  in  1,1,WIDTH  master read beat
- oDTL_OUT_ReadAccept  out  1  master read accept
- oOwner  out  clog2(NUM_PORTS)  registered index of the current owner
- oProtocolError  out  1  sticky: Last did not arrive on the expected beat

## Operation
- States: IDLE, CMD, RDATA, WDATA.
- IDLE: master outputs all 0 and all slave accepts 0.
  - If any CommandValid is high, the winner is the first requesting port at or after rPtr, in ascending order with wrap.
  - Register the winner into rSel, go to CMD.
- CMD: master command fields are a mux of port rSel; CommandAccept goes to rSel only.
  - On the Valid&Accept handshake, latch ReadWrite.
  - Load rBeats = BlockSize.
  - Go to RDATA if read, WDATA if write.
- RDATA: ReadValid, ReadLast and ReadData go to rSel; oDTL_OUT_ReadAccept = iDTL_IN_ReadAccept[rSel].
  - Each read handshake decrements rBeats.
  - A handshake carrying ReadLast returns to IDLE with rPtr = rSel+1 mod NUM_PORTS.
- WDATA: master write signals are a mux of rSel; WriteAccept goes to rSel only. Exit rule is the same as RDATA, using WriteLast.
- Error: Last on a beat where rBeats != 0, or a handshake without Last when rBeats == 0, sets oProtocolError. The FSM still exits only on Last. oProtocolError clears only on reset.
- Non-selected ports always see 0 on every accept, valid, last and data output.
- rBeats is INTERFACE_BLOCK_WIDTH bits and never wraps below 0: it saturates at 0.

## Timing
- Reset (async assert): state IDLE, rSel=0, rPtr=0, rBeats=0, oOwner=0, oProtocolError=0, all outputs 0. Deassertion is synchronised externally.
- Arbitration latency: request seen in IDLE at cycle t gives the master CommandValid at t+1.
- The command handshake at cycle t gives the first data beat eligible at t+1.
- One IDLE bubble cycle follows every transaction, so the minimum turnaround is 1 cycle.
- Requests arriving during a burst wait. Requests dropped before IDLE are not granted.
- A simultaneous Last handshake and a new request: the request is evaluated in the next IDLE cycle with the already-updated rPtr.

## Configuration
- DTL_BURST_ARB_PRIO0_EN defined: in IDLE, port 0 wins whenever its CommandValid is high. Otherwise round-robin applies, and rPtr still advances as normal.
- Not defined: pure round-robin for all ports.

## Structure
- Package dtl_burst_arb_pkg holds:
  - the state enum (IDLE/CMD/RDATA/WDATA)
  - a clog2 function
  - the beat-counter width constant
- Sub-module rr_pick: combinational, inputs request vector and pointer, outputs one-hot plus index. Instantiated once.

## Test plan
- Single read: port 1 read, BlockSize=3, master returns 4 beats with Last on the 4th -> port 1 sees 4 ReadValid beats; port 0 sees all zeros; oProtocolError=0.
- Contention: ports 0 and 1 both request in IDLE with rPtr=0 -> grant order 0 then 1; one IDLE cycle between the two bursts.
- Mid-burst request: port 0 is writing 2 beats and port 1 requests on beat 1 -> port 1 CommandValid reaches the master only after port 0's WriteLast plus 1 cycle.
- Backpressure: a read with ReadAccept low for 3 cycles -> oDTL_OUT_ReadAccept stays low and rBeats is unchanged; the burst completes after release.
- Protocol error: BlockSize=1, ReadLast on beat 1 -> oProtocolError=1 and stays sticky; the FSM returns to IDLE.
- Async reset asserted in WDATA -> all outputs 0 immediately, state IDLE; after release, port 0 request -> master CommandValid 1 cycle later.
